// File: rtl/mc_control.sv
// Multicycle Moore control FSM: sequences fetch/decode/execute/memory/writeback
// and drives the shared-memory strobes. Outputs are combinational from state
// (plus op in IEX/IWB). No backpressure: one state per clock, reset aborts at once.
module mc_control (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic       zero,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       PCWriteCondNe,
    output logic [1:0] PCSource,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       ExtOp,
    output logic [2:0] ALUOp,
    output logic [3:0] state,
    output logic       instr_done,
    output logic       illegal
);

    typedef enum logic [3:0] {
        S_IF   = 4'd0,  S_IRLD = 4'd1,  S_ID   = 4'd2,  S_MADR = 4'd3,
        S_MRD  = 4'd4,  S_MWB  = 4'd5,  S_MWR  = 4'd6,  S_REX  = 4'd7,
        S_RWB  = 4'd8,  S_BEQ  = 4'd9,  S_BNE  = 4'd10, S_JMP  = 4'd11,
        S_IEX  = 4'd12, S_IWB  = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;
    localparam logic [2:0] ALU_AND   = 3'b011;
    localparam logic [2:0] ALU_OR    = 3'b100;
    localparam logic [2:0] ALU_SLT   = 3'b101;

    state_t state_q, state_d;
    state_t cur;

    // The zero flag gates the conditional PC loads in the datapath; this FSM
    // is Moore and only forwards PCWriteCond/PCWriteCondNe.
    logic zero_unused;
    assign zero_unused = zero;

    assign state = state_q;

    // State register; reset forces fetch regardless of the current state.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IF;
        else     state_q <= state_d;
    end

    // Next state and Moore outputs; during reset the mux selects show fetch
    // values and every strobe is held low so an aborted access never writes.
    always_comb begin
        cur           = rst ? S_IF : state_q;
        state_d       = S_IF;
        PCWrite       = 1'b0;
        PCWriteCond   = 1'b0;
        PCWriteCondNe = 1'b0;
        PCSource      = 2'b00;
        IorD          = 1'b0;
        MemRead       = 1'b0;
        MemWrite      = 1'b0;
        IRWrite       = 1'b0;
        RegDst        = 1'b0;
        MemtoReg      = 1'b0;
        RegWrite      = 1'b0;
        ALUSrcA       = 1'b0;
        ALUSrcB       = 2'b00;
        ExtOp         = 1'b0;
        ALUOp         = ALU_ADD;
        instr_done    = 1'b0;
        illegal       = 1'b0;

        case (cur)
            S_IF: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                PCWrite = 1'b1;
                state_d = S_IRLD;
            end
            S_IRLD: begin
                IRWrite = 1'b1;
                state_d = S_ID;
            end
            S_ID: begin
                // Branch target is computed speculatively into ALUOut.
                ALUSrcB = 2'b11;
                ExtOp   = 1'b1;
                case (op)
                    OP_RTYPE:                           state_d = S_REX;
                    OP_LW, OP_SW:                       state_d = S_MADR;
                    OP_BEQ:                             state_d = S_BEQ;
                    OP_BNE:                             state_d = S_BNE;
                    OP_J:                               state_d = S_JMP;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI:  state_d = S_IEX;
                    default: begin
                        state_d = S_IF;
                        illegal = 1'b1;
                    end
                endcase
            end
            S_MADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ExtOp   = 1'b1;
                state_d = (op == OP_SW) ? S_MWR : S_MRD;
            end
            S_MRD: begin
                IorD    = 1'b1;
                MemRead = 1'b1;
                state_d = S_MWB;
            end
            S_MWB: begin
                // IorD stays at ALUOut while the read data lands.
                IorD       = 1'b1;
                MemtoReg   = 1'b1;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_MWR: begin
                IorD       = 1'b1;
                MemWrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_REX: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALU_FUNCT;
                state_d = S_RWB;
            end
            S_RWB: begin
                RegDst     = 1'b1;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_BEQ, S_BNE: begin
                ALUSrcA       = 1'b1;
                ALUOp         = ALU_SUB;
                PCSource      = 2'b01;
                PCWriteCond   = (cur == S_BEQ);
                PCWriteCondNe = (cur == S_BNE);
                instr_done    = 1'b1;
            end
            S_JMP: begin
                PCWrite    = 1'b1;
                PCSource   = 2'b10;
                instr_done = 1'b1;
            end
            S_IEX, S_IWB: begin
                // op is stable until the next IRLD, so the ALU control is
                // re-derived in IWB rather than stored.
                case (op)
                    OP_ANDI: begin ALUOp = ALU_AND; ExtOp = 1'b0; end
                    OP_ORI:  begin ALUOp = ALU_OR;  ExtOp = 1'b0; end
                    OP_SLTI: begin ALUOp = ALU_SLT; ExtOp = 1'b1; end
                    default: begin ALUOp = ALU_ADD; ExtOp = 1'b1; end
                endcase
                if (cur == S_IEX) begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                    state_d = S_IWB;
                end else begin
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                end
            end
            default: state_d = S_IF;
        endcase

        if (rst) begin
            PCWrite       = 1'b0;
            PCWriteCond   = 1'b0;
            PCWriteCondNe = 1'b0;
            MemRead       = 1'b0;
            MemWrite      = 1'b0;
            IRWrite       = 1'b0;
            RegWrite      = 1'b0;
            instr_done    = 1'b0;
            illegal       = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_control.sv
// Bench for mc_control: per-instruction expected control traces built from
// the instruction-class description, compared every cycle at mid-cycle.
// Directed test-plan cases, a mid-store reset, then random opcode streams.
module tb_mc_control;

    logic       clk, rst, zero;
    logic [5:0] op;
    logic       PCWrite, PCWriteCond, PCWriteCondNe, IorD, MemRead, MemWrite;
    logic       IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, ExtOp;
    logic       instr_done, illegal;
    logic [1:0] PCSource, ALUSrcB;
    logic [2:0] ALUOp;
    logic [3:0] state;

    int n_assert = 0;
    int n_fail   = 0;

    mc_control dut (
        .clk(clk), .rst(rst), .op(op), .zero(zero),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCWriteCondNe(PCWriteCondNe),
        .PCSource(PCSource), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ExtOp(ExtOp), .ALUOp(ALUOp),
        .state(state), .instr_done(instr_done), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       pcw, pcwc, pcwcne;
        logic [1:0] pcsrc;
        logic       iord, mrd, mwr, irw, regdst, m2r, regw, srca;
        logic [1:0] srcb;
        logic       ext;
        logic [2:0] aluop;
        logic [3:0] st;
        logic       done, ill;
    } ctl_t;

    ctl_t exp_q[$];

    function automatic ctl_t sample();
        ctl_t c;
        c = '{PCWrite, PCWriteCond, PCWriteCondNe, PCSource, IorD, MemRead, MemWrite,
              IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ExtOp, ALUOp,
              state, instr_done, illegal};
        return c;
    endfunction

    function automatic ctl_t blank(input int st);
        ctl_t c;
        c    = '0;
        c.st = 4'(st);
        return c;
    endfunction

    // Controls seen while rst is high: fetch mux selects, every strobe low.
    function automatic ctl_t reset_view(input int st);
        ctl_t c;
        c      = blank(st);
        c.srcb = 2'b01;
        return c;
    endfunction

    // Reference trace of one instruction, assembled phase by phase.
    task automatic build(input logic [5:0] opc);
        ctl_t c;
        exp_q.delete();
        c = blank(0); c.mrd = 1; c.srcb = 2'b01; c.pcw = 1; exp_q.push_back(c);
        c = blank(1); c.irw = 1;                             exp_q.push_back(c);
        c = blank(2); c.srcb = 2'b11; c.ext = 1;
        case (opc)
            6'b100011: begin                                   // lw
                exp_q.push_back(c);
                c = blank(3); c.srca = 1; c.srcb = 2'b10; c.ext = 1; exp_q.push_back(c);
                c = blank(4); c.iord = 1; c.mrd = 1;                 exp_q.push_back(c);
                c = blank(5); c.iord = 1; c.m2r = 1; c.regw = 1; c.done = 1; exp_q.push_back(c);
            end
            6'b101011: begin                                   // sw
                exp_q.push_back(c);
                c = blank(3); c.srca = 1; c.srcb = 2'b10; c.ext = 1; exp_q.push_back(c);
                c = blank(6); c.iord = 1; c.mwr = 1; c.done = 1;     exp_q.push_back(c);
            end
            6'b000000: begin                                   // R-type
                exp_q.push_back(c);
                c = blank(7); c.srca = 1; c.aluop = 3'b010;           exp_q.push_back(c);
                c = blank(8); c.regdst = 1; c.regw = 1; c.done = 1;   exp_q.push_back(c);
            end
            6'b000100, 6'b000101: begin                        // beq / bne
                exp_q.push_back(c);
                c = blank(opc[0] ? 10 : 9); c.srca = 1; c.aluop = 3'b001;
                c.pcsrc = 2'b01; c.done = 1;
                if (opc[0]) c.pcwcne = 1; else c.pcwc = 1;
                exp_q.push_back(c);
            end
            6'b000010: begin                                   // j
                exp_q.push_back(c);
                c = blank(11); c.pcw = 1; c.pcsrc = 2'b10; c.done = 1; exp_q.push_back(c);
            end
            6'b001000, 6'b001100, 6'b001101, 6'b001010: begin  // immediates
                logic [2:0] a;
                logic       e;
                exp_q.push_back(c);
                a = (opc == 6'b001100) ? 3'b011 : (opc == 6'b001101) ? 3'b100 :
                    (opc == 6'b001010) ? 3'b101 : 3'b000;
                e = !(opc == 6'b001100 || opc == 6'b001101);
                c = blank(12); c.srca = 1; c.srcb = 2'b10; c.aluop = a; c.ext = e; exp_q.push_back(c);
                c = blank(13); c.regw = 1; c.aluop = a; c.ext = e; c.done = 1;    exp_q.push_back(c);
            end
            default: begin                                     // illegal
                c.ill = 1;
                exp_q.push_back(c);
            end
        endcase
    endtask

    task automatic check(input string tag, input ctl_t obs, input ctl_t exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        n_assert++;
        assert (!(obs.mrd === 1'b1 && obs.mwr === 1'b1)) else begin
            n_fail++;
            $error("FAIL %s_rw_excl: observed MemRead=%b MemWrite=%b expected not both 1",
                   tag, obs.mrd, obs.mwr);
        end
    endtask

    // zmode: 0/1 forces zero, anything else randomizes it each cycle.
    // op is garbage during IF/IRLD since the IR is not yet loaded.
    task automatic run_instr(input logic [5:0] opc, input int ncyc, input int zmode);
        build(opc);
        for (int i = 0; i < exp_q.size() && i < ncyc; i++) begin
            @(negedge clk);
            rst  = 1'b0;
            op   = (i < 2) ? 6'($urandom) : opc;
            zero = (zmode == 0 || zmode == 1) ? 1'(zmode) : 1'($urandom);
            #1;
            check($sformatf("op%b_cyc%0d", opc, i), sample(), exp_q[i]);
        end
    endtask

    logic [5:0] legal [10];

    initial begin
        legal = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101,
                  6'b000010, 6'b001000, 6'b001100, 6'b001101, 6'b001010};
        rst  = 1'b1;
        op   = 6'd0;
        zero = 1'b0;

        // Power-up reset
        repeat (2) begin
            @(negedge clk);
            #1;
            check("reset", sample(), reset_view(0));
        end

        // Directed test-plan cases
        run_instr(6'b100011, 99, 2);   // lw
        run_instr(6'b101011, 99, 2);   // sw
        run_instr(6'b000100, 99, 1);   // beq, zero=1
        run_instr(6'b000101, 99, 0);   // bne, zero=0
        run_instr(6'b001101, 99, 2);   // ori
        run_instr(6'b001010, 99, 2);   // slti
        run_instr(6'b111111, 99, 2);   // illegal
        run_instr(6'b000000, 99, 2);   // R-type
        run_instr(6'b000010, 99, 2);   // j
        run_instr(6'b001000, 99, 2);   // addi
        run_instr(6'b001100, 99, 2);   // andi

        // Reset while the store sits in MWR: no write, then back to fetch.
        run_instr(6'b101011, 4, 2);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            rst = 1'b1;
            #1;
            check($sformatf("rst_mwr_%0d", k), sample(), reset_view(k == 0 ? 6 : 0));
        end
        run_instr(6'b100011, 99, 2);

        // Random opcode stream, mostly legal
        for (int n = 0; n < 60; n++) begin
            logic [5:0] r;
            r = ($urandom_range(0, 9) < 8) ? legal[$urandom_range(0, 9)] : 6'($urandom);
            run_instr(r, 99, 2);
        end

        @(negedge clk);
        rst = 1'b0;
        #1;
        n_assert++;
        assert (state === 4'd0) else begin
            n_fail++;
            $error("FAIL final_state: observed %0d expected 0", state);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mc_control.md
# mc_control

Multicycle control FSM that initiates every access to the shared instruction/data memory block. It drives the memory-side strobes (MemRead, MemWrite, IorD, IRWrite) and sequences the datapath (PC, register file, ALU muxes) through fetch, decode, execute, memory and writeback. The FSM is Moore-style, sits beside the datapath, and reads only the IR opcode field and the ALU zero flag. It accounts for the memory's synchronous read: data is valid one cycle after the address is presented.

## Interface
- No parameters.
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- op  in  6  IR[31:26]
- zero  in  1  ALU zero flag
- PCWrite  out  1  unconditional PC load
- PCWriteCond  out  1  PC load if zero==1 (beq)
- PCWriteCondNe  out  1  PC load if zero==0 (bne)
- PCSource  out  2  00 ALU result, 01 ALUOut, 10 jump target
- IorD  out  1  memory address select: 0 PC, 1 ALUOut
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write enable
- IRWrite  out  1  IR capture of memory dataout
- RegDst  out  1  0 rt, 1 rd
- MemtoReg  out  1  0 ALUOut, 1 memory dataout
- RegWrite  out  1  register file write
- ALUSrcA  out  1  0 PC, 1 A
- ALUSrcB  out  2  00 B, 01 const 4, 10 ext imm, 11 ext imm<<2
- ExtOp  out  1  1 sign-extend, 0 zero-extend
- ALUOp  out  3  000 add, 001 sub, 010 funct, 011 and, 100 or, 101 slt
- state  out  4  current state, for debug
- instr_done  out  1  one-cycle pulse in final state of every instruction
- illegal  out  1  one-cycle pulse on unsupported opcode

## Operation
- Encodings: IF=0, IRLD=1, ID=2, MADR=3, MRD=4, MWB=5, MWR=6, REX=7, RWB=8, BEQ=9, BNE=10, JMP=11, IEX=12, IWB=13. Codes 14-15 return to IF.
- All outputs are pure functions of state (and op in IEX/IWB for ALUOp/ExtOp). Unlisted outputs are 0.
- IF: IorD=0, MemRead=1, ALUSrcA=0, ALUSrcB=01, ALUOp=add, PCSource=00, PCWrite=1. Memory latches the old PC; PC becomes PC+4. Next state is IRLD.
- IRLD: IRWrite=1. Next state is ID.
- ID: ALUSrcA=0, ALUSrcB=11, ExtOp=1, ALUOp=add, which puts the branch target in ALUOut. Dispatch on op:
  - 000000 goes to REX.
  - 100011 and 101011 go to MADR.
  - 000100 goes to BEQ; 000101 goes to BNE.
  - 000010 goes to JMP.
  - 001000, 001100, 001101 and 001010 go to IEX.
  - Any other opcode goes to IF with illegal=1.
- MADR: ALUSrcA=1, ALUSrcB=10, ExtOp=1, add. Next state is MRD for lw, MWR for sw.
- MRD: IorD=1, MemRead=1. Next state is MWB.
- MWB: IorD=1 (held), MemtoReg=1, RegDst=0, RegWrite=1, instr_done. Next state is IF.
- MWR: IorD=1, MemWrite=1, instr_done. Next state is IF.
- REX: ALUSrcA=1, ALUSrcB=00, ALUOp=010. Next state is RWB.
- RWB: RegDst=1, RegWrite=1, instr_done. Next state is IF.
- BEQ: ALUSrcA=1, ALUSrcB=00, sub, PCWriteCond=1, PCSource=01, instr_done. Next state is IF.
- BNE: same as BEQ with PCWriteCondNe=1 in place of PCWriteCond.
- JMP: PCWrite=1, PCSource=10, instr_done. Next state is IF.
- IEX: ALUSrcA=1, ALUSrcB=10. Per opcode:
  - addi: add, ExtOp=1.
  - andi: and, ExtOp=0.
  - ori: or, ExtOp=0.
  - slti: slt, ExtOp=1.
  - Next state is IWB.
- IWB: RegDst=0, RegWrite=1, instr_done. ALUOp and ExtOp are held from IEX. Next state is IF.
- MemRead and MemWrite are never both 1. IRWrite is asserted only in IRLD.

## Timing
- rst=1 at a rising edge sets state to IF. While rst=1, all write/strobe outputs are forced to 0: PCWrite, PCWriteCond, PCWriteCondNe, MemRead, MemWrite, IRWrite, RegWrite, instr_done, illegal. Mux selects show IF values.
- A reset mid-instruction (for example in MWR) aborts the instruction immediately, with no write in that cycle. The first cycle after rst is deasserted is IF.
- Cycles per instruction: lw 6, sw 5, R-type 5, immediate 5, beq/bne 4, j 4, illegal 3.
- Memory read latency is 1: an address presented in IF/MRD yields data consumed in IRLD/MWB. IorD is held across each read pair.
- op is sampled only in ID, MADR, IEX and IWB. IR is stable from IRLD+1 until the next IRLD.

## Test plan
- Reset: assert rst for 3 cycles while state=MWR → MemWrite=0 during rst; state=0 after; first post-reset cycle has MemRead=1, IorD=0, PCWrite=1.
- lw (op=100011): from IF, state sequence 0,1,2,3,4,5,0 → MemRead=1 with IorD=1 in state 4; RegWrite=1 with MemtoReg=1 in state 5; instr_done only in state 5.
- sw (op=101011): sequence 0,1,2,3,6,0 → exactly one MemWrite cycle, IorD=1, MemRead=0 in that cycle.
- Branches: beq with zero=1 gives PCWriteCond=1 and PCSource=01 in state 9. bne with zero=0 gives PCWriteCondNe=1 in state 10. Both return to state 0 the next cycle.
- Immediates: ori (001101) in IEX gives ALUOp=100, ExtOp=0, ALUSrcB=10. slti (001010) gives ALUOp=101, ExtOp=1. IWB gives RegWrite=1, RegDst=0.
- Illegal op=111111: sequence 0,1,2,0 with illegal=1 only in state 2 → no RegWrite or MemWrite at any point.
